dtc_master: RTL and testbench



---
 rtl/dtc_pkg.sv | 19 +
 rtl/dtc_sat_cnt.sv | 32 +++
 rtl/dtc_master.sv | 145 ++++++++++++++
 tb/tb_dtc_master.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtc_pkg.sv
// Shared DTC bus definitions: widths, master FSM states and register addresses.
package dtc_pkg;

  localparam int unsigned DTC_ADDR_W = 32;
  localparam int unsigned DTC_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_VLD,
    RESP
  } dtc_master_state_t;

  // Register map, shared with the DTC register slave.
  localparam logic [7:0] CMD_REG_EN  = 8'h01;
  localparam logic [7:0] CMD_THYST   = 8'h04;
  localparam logic [7:0] CMD_HV_BASE = 8'h60;

endpackage

// File: rtl/dtc_sat_cnt.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
import dtc_pkg::*;

module dtc_sat_cnt #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  // Clear wins over increment; increment stops at the top value.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {Width{1'b1}})) begin
      count_d = count_q + Width'(1);
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/dtc_master.sv
// DTC bus initiator: one register read or write at a time, with a bounded
// wait for read data and saturating status counters.
import dtc_pkg::*;

module dtc_master #(
  parameter int unsigned           TIMEOUT_CYCLES = 15,
  parameter logic [DTC_DATA_W-1:0] TIMEOUT_DATA   = 32'hFFFF_FFFF
) (
  input  logic                  dtc_clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [DTC_ADDR_W-1:0] req_address,
  input  logic [DTC_DATA_W-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DTC_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_write,
  output logic                  rsp_timeout,
  output logic [DTC_ADDR_W-1:0] address,
  output logic [DTC_DATA_W-1:0] write_data,
  output logic                  write,
  output logic                  read,
  input  logic [DTC_DATA_W-1:0] read_data,
  input  logic                  data_vld,
  output logic                  busy,
  output logic [15:0]           txn_count,
  output logic [15:0]           timeout_count
);

  localparam logic [7:0] LastWait = 8'(TIMEOUT_CYCLES - 1);

  dtc_master_state_t     state_q;
  logic                  wr_q;
  logic [DTC_ADDR_W-1:0] address_q;
  logic [DTC_DATA_W-1:0] write_data_q;
  logic                  write_q, read_q;
  logic                  rsp_valid_q, rsp_write_q, rsp_timeout_q;
  logic [DTC_DATA_W-1:0] rsp_rdata_q;
  logic [7:0]            wait_cnt_q;
  logic                  rsp_hs;

  // Transaction FSM; strobes and response fields are registered here.
  always_ff @(posedge dtc_clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_q          <= 1'b0;
      address_q     <= '0;
      write_data_q  <= '0;
      write_q       <= 1'b0;
      read_q        <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
      wait_cnt_q    <= '0;
    end else begin
      write_q <= 1'b0;
      read_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            wr_q         <= req_write;
            address_q    <= req_address;
            write_data_q <= req_wdata;
            write_q      <= req_write;
            read_q       <= ~req_write;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          if (wr_q) begin
            // The slave never acknowledges writes; respond right away.
            rsp_valid_q   <= 1'b1;
            rsp_write_q   <= 1'b1;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
            state_q       <= RESP;
          end else begin
            wait_cnt_q <= '0;
            state_q    <= WAIT_VLD;
          end
        end
        WAIT_VLD: begin
          // Data arriving on the expiry cycle still counts as a hit.
          if (data_vld) begin
            rsp_valid_q   <= 1'b1;
            rsp_write_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= read_data;
            state_q       <= RESP;
          end else if (wait_cnt_q == LastWait) begin
            rsp_valid_q   <= 1'b1;
            rsp_write_q   <= 1'b0;
            rsp_timeout_q <= 1'b1;
            rsp_rdata_q   <= TIMEOUT_DATA;
            state_q       <= RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_hs = rsp_valid_q & rsp_ready;

  dtc_sat_cnt #(
    .Width(16)
  ) u_txn_cnt (
    .clk_i  (dtc_clk),
    .clr_i  (rst),
    .inc_i  (rsp_hs),
    .count_o(txn_count)
  );

  dtc_sat_cnt #(
    .Width(16)
  ) u_timeout_cnt (
    .clk_i  (dtc_clk),
    .clr_i  (rst),
    .inc_i  (rsp_hs & rsp_timeout_q),
    .count_o(timeout_count)
  );

  assign req_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_write   = rsp_write_q;
  assign rsp_timeout = rsp_timeout_q;
  assign address     = address_q;
  assign write_data  = write_data_q;
  assign write       = write_q;
  assign read        = read_q;

endmodule

// File: tb/tb_dtc_master.sv
// Scoreboard bench for dtc_master: the sequencer pushes expected strobes and
// responses, independent monitors pop and compare them.
module tb_dtc_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [31:0] req_address = '0, req_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_write, rsp_timeout;
  logic [31:0] rsp_rdata, address, write_data, read_data;
  logic        write, read, data_vld, busy;
  logic [15:0] txn_count, timeout_count;

  logic        sc_clr = 1'b1, sc_inc = 1'b0;
  logic [3:0]  sc_count;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int vld_at = -1;
  logic [31:0] vld_data = '0;
  logic prev_valid = 1'b0;

  typedef struct {
    logic [31:0] rdata;
    logic        wr;
    logic        to;
    int          cyc;
  } rsp_t;

  typedef struct {
    int          cyc;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } stb_t;

  rsp_t rq[$];
  stb_t sq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dtc_master dut (
    .dtc_clk      (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_address  (req_address),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_write    (rsp_write),
    .rsp_timeout  (rsp_timeout),
    .address      (address),
    .write_data   (write_data),
    .write        (write),
    .read         (read),
    .read_data    (read_data),
    .data_vld     (data_vld),
    .busy         (busy),
    .txn_count    (txn_count),
    .timeout_count(timeout_count)
  );

  dtc_sat_cnt #(
    .Width(4)
  ) u_sc (
    .clk_i  (clk),
    .clr_i  (sc_clr),
    .inc_i  (sc_inc),
    .count_o(sc_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Register slave: one data_vld pulse on the scheduled cycle.
  initial begin
    data_vld  = 1'b0;
    read_data = '0;
    forever begin
      @(negedge clk);
      data_vld  = (cyc == vld_at);
      read_data = (cyc == vld_at) ? vld_data : 32'h0;
    end
  end

  // Strobe monitor.
  always @(negedge clk) begin
    if (write || read) begin
      if (sq.size() == 0) begin
        chk("unexpected_strobe", {30'd0, write, read}, 32'd0);
      end else begin
        stb_t e;
        e = sq.pop_front();
        chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
        chk("strobe_write", {31'd0, write}, {31'd0, e.wr});
        chk("strobe_read", {31'd0, read}, {31'd0, ~e.wr});
        chk("strobe_address", address, e.addr);
        chk("strobe_wdata", write_data, e.wdata);
      end
    end
  end

  // Response monitor: fields are checked every valid cycle, so they must stay stable.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (rq.size() == 0) begin
        chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
      end else begin
        if (!prev_valid) chk("rsp_cycle", 32'(cyc), 32'(rq[0].cyc));
        chk("rsp_rdata", rsp_rdata, rq[0].rdata);
        chk("rsp_write", {31'd0, rsp_write}, {31'd0, rq[0].wr});
        chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, rq[0].to});
        if (rsp_ready) void'(rq.pop_front());
      end
    end
    prev_valid = rsp_valid;
  end

  // Issue one request and record what the DUT must do with it.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_to, input int lat,
                       input int vld_off, input logic [31:0] vdata, input bit exp_rsp,
                       input bit hold, output int acc);
    int n = 0;
    @(posedge clk);
    #1;
    req_valid   = 1'b1;
    req_write   = wr;
    req_address = addr;
    req_wdata   = wdata;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("accept_timeout", 32'd0, 32'd1);
    acc = cyc;
    sq.push_back('{cyc: acc + 1, wr: wr, addr: addr, wdata: wdata});
    if (exp_rsp) rq.push_back('{rdata: exp_rdata, wr: wr, to: exp_to, cyc: acc + lat});
    if (vld_off >= 0) begin
      vld_at   = acc + vld_off;
      vld_data = vdata;
    end
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((rq.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_cnts(input logic [15:0] txn, input logic [15:0] to);
    chk("txn_count", {16'd0, txn_count}, {16'd0, txn});
    chk("timeout_count", {16'd0, timeout_count}, {16'd0, to});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int r;
    int n;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_strobes", {30'd0, write, read}, 32'd0);
    chk("rst_address", address, 32'd0);
    chk("rst_write_data", write_data, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk_cnts(16'd0, 16'd0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    sc_clr = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", {31'd0, req_ready}, 32'd1);

    // Write: strobe at T+1, response at T+2.
    issue(1'b1, 32'h04, 32'h5A, 32'h0, 1'b0, 2, -1, 32'h0, 1'b1, 1'b0, acc);
    wait_idle();
    chk_cnts(16'd1, 16'd0);

    // Read with a one-cycle slave: response at T+3.
    issue(1'b0, 32'h50, 32'h0, 32'h0000_0123, 1'b0, 3, 2, 32'h0000_0123, 1'b1, 1'b0, acc);
    wait_idle();
    chk_cnts(16'd2, 16'd0);

    // Read timeout: response at T+17.
    issue(1'b0, 32'h60, 32'h0, 32'hFFFF_FFFF, 1'b1, 17, -1, 32'h0, 1'b1, 1'b0, acc);
    wait_idle();
    chk_cnts(16'd3, 16'd1);

    // Data on the expiry cycle wins.
    issue(1'b0, 32'h61, 32'h0, 32'hCAFE_0001, 1'b0, 17, 16, 32'hCAFE_0001, 1'b1, 1'b0, acc);
    wait_idle();
    chk_cnts(16'd4, 16'd1);

    // data_vld during ISSUE is ignored, so this read times out.
    issue(1'b0, 32'h62, 32'h0, 32'hFFFF_FFFF, 1'b1, 17, 1, 32'hDEAD_BEEF, 1'b1, 1'b0, acc);
    wait_idle();
    chk_cnts(16'd5, 16'd2);

    // Backpressure with a second request held pending.
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    issue(1'b1, 32'h01, 32'h11, 32'h0, 1'b0, 2, -1, 32'h0, 1'b1, 1'b1, acc);
    req_write   = 1'b0;
    req_address = 32'h04;
    req_wdata   = 32'h0;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    r = cyc;
    @(negedge clk);
    chk("bp_next_accept", {31'd0, req_ready}, 32'd1);
    sq.push_back('{cyc: r + 2, wr: 1'b0, addr: 32'h04, wdata: 32'h0});
    rq.push_back('{rdata: 32'h77, wr: 1'b0, to: 1'b0, cyc: r + 4});
    vld_at   = r + 3;
    vld_data = 32'h77;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_idle();
    chk_cnts(16'd7, 16'd2);

    // Reset during WAIT_VLD, with a late data_vld at T+7.
    issue(1'b0, 32'h50, 32'h0, 32'h0, 1'b0, 0, 7, 32'hBAD0_0001, 1'b0, 1'b0, acc);
    while (cyc < acc + 5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
    chk_cnts(16'd0, 16'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
      chk("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    end

    // Normal operation after reset.
    issue(1'b1, 32'h60, 32'hA5A5_0F0F, 32'h0, 1'b0, 2, -1, 32'h0, 1'b1, 1'b0, acc);
    wait_idle();
    chk_cnts(16'd1, 16'd0);

    // Saturation of the counter block on a narrow instance.
    @(posedge clk);
    #1;
    sc_inc = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    sc_inc = 1'b0;
    @(negedge clk);
    chk("sat_near_top", {28'd0, sc_count}, 32'hE);
    @(posedge clk);
    #1;
    sc_inc = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    sc_inc = 1'b0;
    @(negedge clk);
    chk("sat_hold_top", {28'd0, sc_count}, 32'hF);
    @(posedge clk);
    #1;
    sc_clr = 1'b1;
    sc_inc = 1'b1;
    @(posedge clk);
    #1;
    sc_clr = 1'b0;
    sc_inc = 1'b0;
    @(negedge clk);
    chk("sat_clear", {28'd0, sc_count}, 32'h0);

    repeat (3) @(negedge clk);
    chk("rsp_queue_empty", 32'(rq.size()), 32'd0);
    chk("strobe_queue_empty", 32'(sq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
